// File: rtl/johnson_sequence_decoder_if.sv
// ---------------------------------------------------------------------------
// johnson_sequence_decoder_if
//   Bundles the sample-side inputs and the decoded/status outputs of the
//   Johnson sequence decoder.
//
//   master : the producer/consumer side (drives john_in, sample_en, clr and
//            observes the decoded state).
//   slave  : the decoder itself.
//
//   Signals
//     john_in    N       Johnson code from the counter
//     sample_en  1       qualifies john_in for this cycle
//     clr        1       synchronous fault/lock clear
//     idx        IW      decoded index of the last legal sample
//     code_ok    1       last sample was a legal Johnson code
//     dir_down   1       direction of the last non-hold step (1 = down)
//     locked     1       decoder is locked onto a steady direction
//     fault      1       decoder has latched a fault
//     fault_type 2       01 illegal, 10 skip/jump, 11 reversal, 00 none
//     wrap_cnt   WRAP_W  saturating count of wraps in either direction
// ---------------------------------------------------------------------------
interface johnson_sequence_decoder_if #(
  parameter int N      = 4,
  parameter int WRAP_W = 8
);
  localparam int IW = $clog2(2 * N);

  logic [N-1:0]      john_in;
  logic              sample_en;
  logic              clr;
  logic [IW-1:0]     idx;
  logic              code_ok;
  logic              dir_down;
  logic              locked;
  logic              fault;
  logic [1:0]        fault_type;
  logic [WRAP_W-1:0] wrap_cnt;

  modport master (
    output john_in, sample_en, clr,
    input  idx, code_ok, dir_down, locked, fault, fault_type, wrap_cnt
  );

  modport slave (
    input  john_in, sample_en, clr,
    output idx, code_ok, dir_down, locked, fault, fault_type, wrap_cnt
  );
endinterface

// File: rtl/johnson_sequence_decoder.sv
// ---------------------------------------------------------------------------
// johnson_sequence_decoder
//   Receive-side checker/decoder for a 2N-state Johnson counter. Each
//   qualified sample is checked for legality, decoded to a binary index and
//   classified against the previously stored index (hold / up / down / jump /
//   illegal). A small FSM acquires a direction, locks after LOCK_CNT
//   consecutive same-direction steps, and latches a sticky fault on an
//   illegal code, a skipped state or a reversal while locked.
//
//   Ports
//     clk   in  system clock, rising edge
//     rst   in  asynchronous, active-low reset
//     bus   slave modport of johnson_sequence_decoder_if (see that file)
//
//   All outputs are registered and move only on an edge where clr = 1 or
//   sample_en = 1; clr has priority and discards a coincident sample.
// ---------------------------------------------------------------------------
module johnson_sequence_decoder #(
  parameter int N        = 4,
  parameter int LOCK_CNT = 3,
  parameter int WRAP_W   = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  johnson_sequence_decoder_if.slave bus
);

  localparam int STATES = 2 * N;
  localparam int IW     = $clog2(STATES);
  localparam int PW     = $clog2(N + 1);
  localparam int RW     = $clog2(LOCK_CNT + 1);

  localparam logic [IW-1:0] LAST_IDX = IW'(STATES - 1);
  localparam logic [RW-1:0] LOCK_RUN = RW'(LOCK_CNT);

  localparam logic [1:0] FT_NONE    = 2'b00;
  localparam logic [1:0] FT_ILLEGAL = 2'b01;
  localparam logic [1:0] FT_JUMP    = 2'b10;
  localparam logic [1:0] FT_REVERSE = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2,
    FAULT  = 2'd3
  } state_t;

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  state_t            state_reg,      state_next;
  logic [IW-1:0]     idx_reg,        idx_next;
  logic              code_ok_reg,    code_ok_next;
  logic              dir_down_reg,   dir_down_next;
  logic [RW-1:0]     run_reg,        run_next;
  logic [WRAP_W-1:0] wrap_reg,       wrap_next;
  logic [1:0]        fault_type_reg, fault_type_next;

  // -------------------------------------------------------------------------
  // Legality: a legal code is a contiguous run of ones anchored either at
  // bit 0 (ones fill from the bottom) or at bit N-1 (ones fill from the top).
  // Bottom-anchored means no 0 ever sits directly below a 1; top-anchored
  // means no 1 ever sits directly below a 0. All-zero and all-one satisfy
  // both.
  // -------------------------------------------------------------------------
  logic [N-1:0] code;
  logic [N-2:0] zero_below_one;
  logic [N-2:0] one_below_zero;
  logic         legal;

  assign code = bus.john_in;

  generate
    for (genvar gi = 0; gi < N - 1; gi++) begin : g_adjacent
      assign zero_below_one[gi] = ~code[gi] &  code[gi+1];
      assign one_below_zero[gi] =  code[gi] & ~code[gi+1];
    end
  endgenerate

  assign legal = ~(|zero_below_one) | ~(|one_below_zero);

  // -------------------------------------------------------------------------
  // Decode: the first half of the cycle fills ones from the bottom (msb = 0,
  // index = number of ones); the second half empties them from the bottom
  // (msb = 1, index = 2N - number of ones).
  // -------------------------------------------------------------------------
  logic [PW-1:0] pop;
  logic [IW-1:0] dec_idx;

  always_comb begin
    pop = '0;
    for (int i = 0; i < N; i++) begin
      pop = pop + PW'(code[i]);
    end
  end

  always_comb begin
    if (code[N-1]) begin
      dec_idx = IW'(STATES - int'(pop));
    end else begin
      dec_idx = IW'(pop);
    end
  end

  // -------------------------------------------------------------------------
  // Step classification relative to the stored index (modulo 2N).
  // -------------------------------------------------------------------------
  logic [IW-1:0] up_idx;
  logic [IW-1:0] down_idx;
  logic          step_hold;
  logic          step_up;
  logic          step_down;
  logic          step_move;
  logic          step_jump;
  logic          wrap_step;

  assign up_idx   = (idx_reg == LAST_IDX) ? '0       : idx_reg + IW'(1);
  assign down_idx = (idx_reg == '0)       ? LAST_IDX : idx_reg - IW'(1);

  assign step_hold = legal && (dec_idx == idx_reg);
  assign step_up   = legal && !step_hold && (dec_idx == up_idx);
  assign step_down = legal && !step_hold && !step_up && (dec_idx == down_idx);
  assign step_move = step_up || step_down;
  assign step_jump = legal && !step_hold && !step_move;

  // A wrap is crossing the 2N-1 <-> 0 seam by a single step.
  assign wrap_step = (step_up   && (idx_reg == LAST_IDX)) ||
                     (step_down && (idx_reg == '0));

  // -------------------------------------------------------------------------
  // Next-state and datapath logic
  // -------------------------------------------------------------------------
  logic [RW-1:0] run_step;

  always_comb begin
    state_next      = state_reg;
    idx_next        = idx_reg;
    code_ok_next    = code_ok_reg;
    dir_down_next   = dir_down_reg;
    run_next        = run_reg;
    wrap_next       = wrap_reg;
    fault_type_next = fault_type_reg;
    run_step        = '0;

    if (bus.clr) begin
      // Clear wins over a coincident sample; index and wrap history survive.
      state_next      = IDLE;
      run_next        = '0;
      fault_type_next = FT_NONE;
    end else if (bus.sample_en) begin
      code_ok_next = legal;
      if (legal) begin
        idx_next = dec_idx;
      end

      // Wraps are counted only while tracking (not in IDLE, frozen in FAULT).
      if (wrap_step && (state_reg == ACQ || state_reg == LOCKED) &&
          (wrap_reg != '1)) begin
        wrap_next = wrap_reg + WRAP_W'(1);
      end

      unique case (state_reg)
        IDLE: begin
          if (legal) begin
            state_next = ACQ;
            run_next   = '0;
          end
        end

        ACQ: begin
          if (!legal) begin
            state_next = IDLE;
            run_next   = '0;
          end else if (step_jump) begin
            run_next = '0;
          end else if (step_move) begin
            // A fresh run (run = 0) adopts whatever direction it sees; a step
            // against an established run restarts the count at one.
            if ((run_reg == '0) || (step_down == dir_down_reg)) begin
              run_step = run_reg + RW'(1);
            end else begin
              run_step = RW'(1);
            end
            dir_down_next = step_down;
            run_next      = run_step;
            if (run_step == LOCK_RUN) begin
              state_next = LOCKED;
            end
          end
        end

        LOCKED: begin
          if (!legal) begin
            state_next      = FAULT;
            fault_type_next = FT_ILLEGAL;
          end else if (step_jump) begin
            state_next      = FAULT;
            fault_type_next = FT_JUMP;
          end else if (step_move && (step_down != dir_down_reg)) begin
            state_next      = FAULT;
            fault_type_next = FT_REVERSE;
          end
        end

        FAULT: begin
          // Sticky: only clr or reset leaves this state.
        end

        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= IDLE;
      idx_reg        <= '0;
      code_ok_reg    <= 1'b0;
      dir_down_reg   <= 1'b0;
      run_reg        <= '0;
      wrap_reg       <= '0;
      fault_type_reg <= FT_NONE;
    end else begin
      state_reg      <= state_next;
      idx_reg        <= idx_next;
      code_ok_reg    <= code_ok_next;
      dir_down_reg   <= dir_down_next;
      run_reg        <= run_next;
      wrap_reg       <= wrap_next;
      fault_type_reg <= fault_type_next;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs (all straight from registers)
  // -------------------------------------------------------------------------
  assign bus.idx        = idx_reg;
  assign bus.code_ok    = code_ok_reg;
  assign bus.dir_down   = dir_down_reg;
  assign bus.locked     = (state_reg == LOCKED);
  assign bus.fault      = (state_reg == FAULT);
  assign bus.fault_type = fault_type_reg;
  assign bus.wrap_cnt   = wrap_reg;

endmodule

// File: tb/tb_johnson_sequence_decoder.sv
// ---------------------------------------------------------------------------
// tb_johnson_sequence_decoder
//   Directed and randomized stimulus for johnson_sequence_decoder (N=4,
//   LOCK_CNT=3, WRAP_W=8). Expected outputs come from a behavioural model
//   that derives the code table by running the counter rule and classifies
//   steps with modular index arithmetic.
// ---------------------------------------------------------------------------
module tb_johnson_sequence_decoder;

  localparam int N      = 4;
  localparam int NS     = 2 * N;
  localparam int LOCK   = 3;
  localparam int WRAP_W = 8;
  localparam int WMAX   = (1 << WRAP_W) - 1;

  localparam int M_IDLE   = 0;
  localparam int M_ACQ    = 1;
  localparam int M_LOCKED = 2;
  localparam int M_FAULT  = 3;

  logic clk;
  logic rst;

  johnson_sequence_decoder_if #(.N(N), .WRAP_W(WRAP_W)) bus ();

  johnson_sequence_decoder #(
    .N       (N),
    .LOCK_CNT(LOCK),
    .WRAP_W  (WRAP_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int   code2idx [16];
  logic [3:0] idx2code [NS];
  int   m_state;
  int   m_idx;
  bit   m_code_ok;
  bit   m_dir_down;
  int   m_run;
  int   m_wrap;
  int   m_ftype;

  function automatic void build_table();
    logic [3:0] c;
    for (int i = 0; i < 16; i++) code2idx[i] = -1;
    c = 4'b0000;
    for (int i = 0; i < NS; i++) begin
      code2idx[c] = i;
      idx2code[i] = c;
      c = {c[2:0], ~c[3]};   // counting up: shift left, insert inverted msb
    end
  endfunction

  function automatic void model_reset();
    m_state = M_IDLE; m_idx = 0; m_code_ok = 0; m_dir_down = 0;
    m_run = 0; m_wrap = 0; m_ftype = 0;
  endfunction

  function automatic void model_sample(input logic [3:0] code, input bit en, input bit c);
    int ni, old, delta;
    bit lg, up, dn, hold, jump;
    if (c) begin
      m_state = M_IDLE; m_run = 0; m_ftype = 0;
      return;
    end
    if (!en) return;
    ni   = code2idx[code];
    lg   = (ni >= 0);
    old  = m_idx;
    delta = lg ? ((ni - old + NS) % NS) : -1;
    hold = (delta == 0);
    up   = (delta == 1);
    dn   = (delta == NS - 1);
    jump = lg && !hold && !up && !dn;
    m_code_ok = lg;
    if (lg) m_idx = ni;
    if ((m_state == M_ACQ || m_state == M_LOCKED) &&
        ((up && old == NS - 1) || (dn && old == 0)) && m_wrap < WMAX)
      m_wrap++;
    case (m_state)
      M_IDLE: if (lg) begin m_state = M_ACQ; m_run = 0; end
      M_ACQ: begin
        if (!lg) begin m_state = M_IDLE; m_run = 0; end
        else if (jump) m_run = 0;
        else if (up || dn) begin
          if (m_run == 0 || dn == m_dir_down) m_run++;
          else m_run = 1;
          m_dir_down = dn;
          if (m_run == LOCK) m_state = M_LOCKED;
        end
      end
      M_LOCKED: begin
        if (!lg) begin m_state = M_FAULT; m_ftype = 1; end
        else if (jump) begin m_state = M_FAULT; m_ftype = 2; end
        else if ((up || dn) && dn != m_dir_down) begin m_state = M_FAULT; m_ftype = 3; end
      end
      default: ;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".idx"},        32'(bus.idx),        32'(m_idx));
    chk({tag, ".code_ok"},    32'(bus.code_ok),    32'(m_code_ok));
    chk({tag, ".dir_down"},   32'(bus.dir_down),   32'(m_dir_down));
    chk({tag, ".locked"},     32'(bus.locked),     32'(m_state == M_LOCKED));
    chk({tag, ".fault"},      32'(bus.fault),      32'(m_state == M_FAULT));
    chk({tag, ".fault_type"}, 32'(bus.fault_type), 32'(m_ftype));
    chk({tag, ".wrap_cnt"},   32'(bus.wrap_cnt),   32'(m_wrap));
  endtask

  task automatic cycle(input logic [3:0] code, input bit en, input bit c, input string tag);
    @(negedge clk);
    bus.john_in   = code;
    bus.sample_en = en;
    bus.clr       = c;
    @(posedge clk);
    model_sample(code, en, c);
    #1;
    check_all(tag);
  endtask

  task automatic samp(input logic [3:0] code, input string tag);
    cycle(code, 1'b1, 1'b0, tag);
  endtask

  task automatic do_clr(input string tag);
    cycle(4'b0000, 1'b0, 1'b1, tag);
  endtask

  initial begin
    int saved_idx, saved_wrap, sel, r;
    bit pref_down, en, c;
    logic [3:0] code;

    build_table();
    model_reset();
    rst           = 1'b0;
    bus.john_in   = 4'b0000;
    bus.sample_en = 1'b0;
    bus.clr       = 1'b0;

    // Reset held for two cycles
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    rst = 1'b1;

    // Down sequence from 0000
    samp(4'b0000, "down0");
    chk("down0.idx", 32'(bus.idx), 32'd0);
    samp(4'b1000, "down1");
    chk("down1.idx", 32'(bus.idx), 32'd7);
    chk("down1.wrap", 32'(bus.wrap_cnt), 32'd1);
    chk("down1.dir", 32'(bus.dir_down), 32'd1);
    samp(4'b1100, "down2");
    chk("down2.locked", 32'(bus.locked), 32'd0);
    samp(4'b1110, "down3");
    chk("down3.idx", 32'(bus.idx), 32'd5);
    chk("down3.locked", 32'(bus.locked), 32'd1);

    // Continue the down circuit to 36 samples total
    for (int k = 0; k < 32; k++) samp(idx2code[(m_idx + NS - 1) % NS], "circuit");
    chk("circuit.locked", 32'(bus.locked), 32'd1);
    chk("circuit.fault", 32'(bus.fault), 32'd0);

    // sample_en low: everything frozen
    saved_idx  = m_idx;
    saved_wrap = m_wrap;
    for (int k = 0; k < 5; k++) cycle(4'($urandom_range(0, 15)), 1'b0, 1'b0, "freeze");
    chk("freeze.idx", 32'(bus.idx), 32'(saved_idx));
    chk("freeze.wrap", 32'(bus.wrap_cnt), 32'(saved_wrap));

    // Lock going up, then an illegal code
    do_clr("clr1");
    samp(4'b0000, "up0"); samp(4'b0001, "up1"); samp(4'b0011, "up2"); samp(4'b0111, "up3");
    chk("up3.locked", 32'(bus.locked), 32'd1);
    samp(4'b0101, "illegal");
    chk("illegal.fault_type", 32'(bus.fault_type), 32'd1);
    chk("illegal.idx", 32'(bus.idx), 32'd3);
    chk("illegal.code_ok", 32'(bus.code_ok), 32'd0);
    do_clr("clr2");
    chk("clr2.fault", 32'(bus.fault), 32'd0);

    // Reversal while locked at idx 3
    samp(4'b0000, "rv0"); samp(4'b0001, "rv1"); samp(4'b0011, "rv2"); samp(4'b0111, "rv3");
    samp(4'b0011, "reverse");
    chk("reverse.fault_type", 32'(bus.fault_type), 32'd3);
    do_clr("clr3");

    // Lock up onto idx 0 then jump to 1111
    samp(4'b1110, "jp0"); samp(4'b1100, "jp1"); samp(4'b1000, "jp2"); samp(4'b0000, "jp3");
    chk("jp3.locked", 32'(bus.locked), 32'd1);
    samp(4'b1111, "jump");
    chk("jump.fault_type", 32'(bus.fault_type), 32'd2);
    samp(4'b0111, "in_fault");
    chk("in_fault.idx", 32'(bus.idx), 32'd3);
    chk("in_fault.fault", 32'(bus.fault), 32'd1);
    do_clr("clr4");

    // ACQ: up, up, down restarts the run; a hold does not reset it
    samp(4'b0000, "acq0"); samp(4'b0001, "acq1"); samp(4'b0011, "acq2");
    samp(4'b0001, "acq_rev");
    chk("acq_rev.dir", 32'(bus.dir_down), 32'd1);
    chk("acq_rev.locked", 32'(bus.locked), 32'd0);
    samp(4'b0001, "acq_hold");
    samp(4'b0000, "acq_dn2");
    chk("acq_dn2.locked", 32'(bus.locked), 32'd0);
    samp(4'b1000, "acq_dn3");
    chk("acq_dn3.locked", 32'(bus.locked), 32'd1);
    do_clr("clr5");

    // Illegal code in ACQ returns to IDLE without a fault
    samp(4'b0000, "ai0"); samp(4'b0001, "ai1");
    samp(4'b1010, "acq_illegal");
    chk("acq_illegal.fault", 32'(bus.fault), 32'd0);
    samp(4'b0011, "ai2"); samp(4'b0111, "ai3"); samp(4'b1111, "ai4");

    // clr and sample_en together: clr wins, sample discarded
    cycle(4'b0101, 1'b1, 1'b1, "clr_and_sample");

    // Randomized phase
    pref_down = 1'b0;
    for (int k = 0; k < 400; k++) begin
      r   = $urandom_range(0, 19);
      c   = (r == 0);
      en  = (r != 1);
      sel = $urandom_range(0, 9);
      if (sel < 5)      code = idx2code[(m_idx + (pref_down ? NS - 1 : 1)) % NS];
      else if (sel < 7) code = idx2code[m_idx];
      else if (sel < 8) code = idx2code[(m_idx + (pref_down ? 1 : NS - 1)) % NS];
      else              code = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 29) == 0) pref_down = !pref_down;
      cycle(code, en, c, "rand");
    end

    // Async reset mid-run while locked with wrap_cnt = 2
    @(negedge clk); rst = 1'b0; model_reset();
    @(negedge clk); rst = 1'b1;
    samp(4'b0000, "ar0");
    for (int k = 0; k < 9; k++) samp(idx2code[(m_idx + NS - 1) % NS], "ar_run");
    chk("ar_run.wrap", 32'(bus.wrap_cnt), 32'd2);
    chk("ar_run.locked", 32'(bus.locked), 32'd1);
    @(posedge clk);
    #3 rst = 1'b0;
    model_reset();
    #1 check_all("async_rst");
    @(negedge clk); rst = 1'b1;
    samp(4'b0011, "ar_acq");
    samp(4'b0111, "ar_acq1"); samp(4'b1111, "ar_acq2"); samp(4'b1110, "ar_acq3");
    chk("ar_acq3.locked", 32'(bus.locked), 32'd1);

    // Wrap counter saturation on a long up run
    do_clr("clr6");
    for (int k = 0; k < NS * 260; k++) samp(idx2code[(m_idx + 1) % NS], "sat");
    chk("sat.wrap", 32'(bus.wrap_cnt), 32'hFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
